prga_gen: RTL and testbench

Parametrised ARC4 pseudo-random generation stage that decrypts a length-prefixed ciphertext into plaintext memory. It operates on an already key-scheduled S-box (256x8).
- Generalises the existing single-mode PRGA with a configurable message address width.
- Adds an optional RC4-drop[n] keystream discard.
- Adds a configurable printable-range key check, with sticky failure, first-fail index and optional early abort.
- Sits between ksa and the crack controller; driven by an en/rdy handshake.

---
 rtl/arc4_pkg.sv | 33 +++
 rtl/prga_gen_if.sv | 34 +++
 rtl/prga_keycheck.sv | 52 +++++
 rtl/prga_gen.sv | 199 +++++++++++++++++++
 tb/tb_prga_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding, S-box geometry and the
// default printable range used by the key check. Also used by ksa and the
// crack controller.
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam int S_AW    = $clog2(S_DEPTH);

  typedef logic [S_AW-1:0] s_idx_t;

  localparam logic [7:0] CHK_LO_DEF = 8'h20;
  localparam logic [7:0] CHK_HI_DEF = 8'h7E;

  typedef enum logic [3:0] {
    PRGA_IDLE,
    PRGA_LEN,
    PRGA_SI,
    PRGA_SJ,
    PRGA_WJ,
    PRGA_WI,
    PRGA_PAD,
    PRGA_OUT,
    PRGA_DONE
  } prga_state_e;

  // True when b lies inside the inclusive range [lo, hi].
  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/prga_gen_if.sv
// Handshake and memory bus of the PRGA stage. The master side is the PRGA
// engine; the slave side is the controller plus the S/ct/pt memories.
interface prga_gen_if #(
  parameter int CT_AW = 8
);

  logic             en;
  logic             rdy;
  logic             done;
  logic [7:0]       s_addr;
  logic [7:0]       s_rddata;
  logic [7:0]       s_wrdata;
  logic             s_wren;
  logic [CT_AW-1:0] ct_addr;
  logic [7:0]       ct_rddata;
  logic [CT_AW-1:0] pt_addr;
  logic [7:0]       pt_wrdata;
  logic             pt_wren;
  logic             key_fail;
  logic [CT_AW-1:0] fail_idx;

  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, done, s_addr, s_wrdata, s_wren, ct_addr,
           pt_addr, pt_wrdata, pt_wren, key_fail, fail_idx
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, done, s_addr, s_wrdata, s_wren, ct_addr,
           pt_addr, pt_wrdata, pt_wren, key_fail, fail_idx
  );

endinterface

// File: rtl/prga_keycheck.sv
// Printable-range check on plaintext bytes. The range test is combinational;
// key_fail is sticky and fail_idx latches the index of the first failure.
module prga_keycheck
  import arc4_pkg::*;
#(
  parameter int         IDX_W  = 8,
  parameter logic [7:0] CHK_LO = CHK_LO_DEF,
  parameter logic [7:0] CHK_HI = CHK_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [7:0]       data,
  input  logic [IDX_W-1:0] idx,
  output logic             byte_fail,
  output logic             key_fail,
  output logic [IDX_W-1:0] fail_idx
);

  logic             key_fail_q, key_fail_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  assign byte_fail = !in_range(data, CHK_LO, CHK_HI);
  assign key_fail  = key_fail_q;
  assign fail_idx  = fail_idx_q;

  // Clear at run start; capture only the first failing byte of a run.
  always_comb begin
    key_fail_d = key_fail_q;
    fail_idx_d = fail_idx_q;
    if (clr) begin
      key_fail_d = 1'b0;
      fail_idx_d = '0;
    end else if (load && byte_fail && !key_fail_q) begin
      key_fail_d = 1'b1;
      fail_idx_d = idx;
    end
  end

  // Sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_fail_q <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      key_fail_q <= key_fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

endmodule

// File: rtl/prga_gen.sv
// ARC4 pseudo-random generation stage. Reads the length byte at ct[0],
// copies it to pt[0], then for each message byte performs the i/j update and
// S swap and XORs the keystream byte into ct[k] -> pt[k]. The first DROP
// keystream bytes are generated but discarded.
module prga_gen
  import arc4_pkg::*;
#(
  parameter int         CT_AW         = 8,
  parameter int         DROP          = 0,
  parameter logic [7:0] CHK_LO        = CHK_LO_DEF,
  parameter logic [7:0] CHK_HI        = CHK_HI_DEF,
  parameter bit         ABORT_ON_FAIL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  prga_gen_if.master  bus
);

  localparam logic [15:0] DROP_C = 16'(DROP);

  prga_state_e      state_q, state_d;
  s_idx_t           i_q, i_d;
  s_idx_t           j_q, j_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;
  logic [CT_AW-1:0] k_q, k_d;
  logic [CT_AW-1:0] len_q, len_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             rdy_c, done_c;
  logic [7:0]       s_addr_c, s_wrdata_c;
  logic             s_wren_c;
  logic [CT_AW-1:0] ct_addr_c, pt_addr_c;
  logic [7:0]       pt_wrdata_c;
  logic             pt_wren_c;
  logic             kc_clr, kc_load;

  logic [CT_AW-1:0] len_in;
  logic [7:0]       pt_byte;
  logic             byte_fail;
  logic             drop_active;
  logic             key_fail_w;
  logic [CT_AW-1:0] fail_idx_w;

  // Length byte is taken from the low bits of ct[0].
  assign len_in      = CT_AW'(bus.ct_rddata);
  assign pt_byte     = bus.s_rddata ^ bus.ct_rddata;
  // drop_cnt stops at DROP, so inequality means discard bytes remain.
  assign drop_active = (drop_cnt_q != DROP_C);

  prga_keycheck #(
    .IDX_W  (CT_AW),
    .CHK_LO (CHK_LO),
    .CHK_HI (CHK_HI)
  ) u_keycheck (
    .clk       (clk),
    .rst       (rst),
    .clr       (kc_clr),
    .load      (kc_load),
    .data      (pt_byte),
    .idx       (k_q),
    .byte_fail (byte_fail),
    .key_fail  (key_fail_w),
    .fail_idx  (fail_idx_w)
  );

  assign bus.rdy       = rdy_c;
  assign bus.done      = done_c;
  assign bus.s_addr    = s_addr_c;
  assign bus.s_wrdata  = s_wrdata_c;
  assign bus.s_wren    = s_wren_c;
  assign bus.ct_addr   = ct_addr_c;
  assign bus.pt_addr   = pt_addr_c;
  assign bus.pt_wrdata = pt_wrdata_c;
  assign bus.pt_wren   = pt_wren_c;
  assign bus.key_fail  = key_fail_w;
  assign bus.fail_idx  = fail_idx_w;

  // Next-state logic and combinational memory strobes; one S access per cycle.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    k_d         = k_q;
    len_d       = len_q;
    drop_cnt_d  = drop_cnt_q;
    rdy_c       = 1'b0;
    done_c      = 1'b0;
    s_addr_c    = '0;
    s_wrdata_c  = '0;
    s_wren_c    = 1'b0;
    ct_addr_c   = '0;
    pt_addr_c   = '0;
    pt_wrdata_c = '0;
    pt_wren_c   = 1'b0;
    kc_clr      = 1'b0;
    kc_load     = 1'b0;

    unique case (state_q)
      PRGA_IDLE: begin
        rdy_c = 1'b1;
        // ct_addr stays 0 so the length byte is on ct_rddata in LEN.
        if (bus.en) begin
          state_d    = PRGA_LEN;
          kc_clr     = 1'b1;
          i_d        = '0;
          j_d        = '0;
          drop_cnt_d = '0;
          k_d        = CT_AW'(1);
        end
      end
      PRGA_LEN: begin
        len_d       = len_in;
        pt_addr_c   = '0;
        pt_wrdata_c = bus.ct_rddata;
        pt_wren_c   = 1'b1;
        state_d     = (len_in == '0) ? PRGA_DONE : PRGA_SI;
      end
      PRGA_SI: begin
        i_d      = i_q + 8'd1;
        s_addr_c = i_q + 8'd1;
        state_d  = PRGA_SJ;
      end
      PRGA_SJ: begin
        si_d     = bus.s_rddata;
        j_d      = j_q + bus.s_rddata;
        s_addr_c = j_q + bus.s_rddata;
        state_d  = PRGA_WJ;
      end
      PRGA_WJ: begin
        sj_d       = bus.s_rddata;
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
        state_d    = PRGA_WI;
      end
      PRGA_WI: begin
        s_addr_c   = i_q;
        s_wrdata_c = sj_q;
        s_wren_c   = 1'b1;
        state_d    = PRGA_PAD;
      end
      PRGA_PAD: begin
        s_addr_c  = si_q + sj_q;
        ct_addr_c = k_q;
        state_d   = PRGA_OUT;
      end
      PRGA_OUT: begin
        if (drop_active) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = PRGA_SI;
        end else begin
          pt_addr_c   = k_q;
          pt_wrdata_c = pt_byte;
          pt_wren_c   = 1'b1;
          kc_load     = 1'b1;
          // Termination is tested before the increment so k never wraps.
          if ((ABORT_ON_FAIL && byte_fail) || (k_q == len_q)) begin
            state_d = PRGA_DONE;
          end else begin
            k_d     = k_q + CT_AW'(1);
            state_d = PRGA_SI;
          end
        end
      end
      PRGA_DONE: begin
        done_c  = 1'b1;
        state_d = PRGA_IDLE;
      end
      default: state_d = PRGA_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRGA_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= CT_AW'(1);
      len_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_prga_gen.sv
// Directed bench for prga_gen. Three instances: inst 0 = DROP 0 / abort on,
// inst 1 = DROP 1 / abort on, inst 2 = DROP 0 / abort off. Each has its own
// S, ct and pt memory model with 1-cycle read latency.
module tb_prga_gen;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [N-1:0]      en, rdy, done, s_wren, pt_wren, key_fail;
  logic [N-1:0][7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata;
  logic [N-1:0][7:0] pt_addr, pt_wrdata, fail_idx;

  logic [7:0] s_mem  [N][256];
  logic [7:0] ct_mem [N][256];
  logic [7:0] pt_mem [N][256];
  int         swr_cnt [N];
  int         ptw_cnt [N];

  logic       init_req;
  int         init_inst;
  logic [7:0] init_ct [4];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    prga_gen_if #(.CT_AW(8)) bus ();

    assign bus.en         = en[gi];
    assign bus.s_rddata   = s_rddata[gi];
    assign bus.ct_rddata  = ct_rddata[gi];
    assign rdy[gi]        = bus.rdy;
    assign done[gi]       = bus.done;
    assign s_addr[gi]     = bus.s_addr;
    assign s_wrdata[gi]   = bus.s_wrdata;
    assign s_wren[gi]     = bus.s_wren;
    assign ct_addr[gi]    = bus.ct_addr;
    assign pt_addr[gi]    = bus.pt_addr;
    assign pt_wrdata[gi]  = bus.pt_wrdata;
    assign pt_wren[gi]    = bus.pt_wren;
    assign key_fail[gi]   = bus.key_fail;
    assign fail_idx[gi]   = bus.fail_idx;

    prga_gen #(
      .CT_AW         (8),
      .DROP          ((gi == 1) ? 1 : 0),
      .CHK_LO        (8'h20),
      .CHK_HI        (8'h7E),
      .ABORT_ON_FAIL ((gi == 2) ? 1'b0 : 1'b1)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );
  end

  // Memory models: identity S reload, ct load and pt sentinel fill on init_req.
  always @(posedge clk) begin
    for (int n = 0; n < N; n++) begin
      if (init_req && init_inst == n) begin
        for (int x = 0; x < 256; x++) begin
          s_mem[n][x]  <= 8'(x);
          ct_mem[n][x] <= 8'h00;
          pt_mem[n][x] <= 8'hEE;
        end
        for (int x = 0; x < 4; x++) ct_mem[n][x] <= init_ct[x];
        swr_cnt[n] <= 0;
        ptw_cnt[n] <= 0;
      end else begin
        if (s_wren[n]) begin
          s_mem[n][s_addr[n]] <= s_wrdata[n];
          swr_cnt[n] <= swr_cnt[n] + 1;
        end
        if (pt_wren[n]) begin
          pt_mem[n][pt_addr[n]] <= pt_wrdata[n];
          ptw_cnt[n] <= ptw_cnt[n] + 1;
        end
      end
      s_rddata[n]  <= s_mem[n][s_addr[n]];
      ct_rddata[n] <= ct_mem[n][ct_addr[n]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    @(negedge clk);
    init_inst  = n;
    init_ct[0] = b0;
    init_ct[1] = b1;
    init_ct[2] = b2;
    init_ct[3] = b3;
    init_req   = 1'b1;
    @(negedge clk);
    init_req   = 1'b0;
  endtask

  // Start one run on instance n; cyc = edges from the accept edge to done.
  task automatic run(input int n, input bit hold, output int cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rdy[n] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rdy_before_run", 32'(rdy[n]), 1);
    en[n] = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    if (!hold) en[n] = 1'b0;
    while (!done[n] && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("done_seen", 32'(done[n]), 1);
    en[n] = 1'b0;
    @(negedge clk);
    check("rdy_after_done", 32'(rdy[n]), 1);
    check("done_one_cycle", 32'(done[n]), 0);
    $display("run inst %0d len %0d cycles %0d key_fail %0d fail_idx %0d",
             n, ct_mem[n][0], cyc, key_fail[n], fail_idx[n]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    en        = '0;
    rst       = 1'b1;
    init_req  = 1'b0;
    init_inst = 0;
    for (int x = 0; x < 4; x++) init_ct[x] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state on every instance.
    for (int n = 0; n < N; n++) begin
      check("rst_rdy",      32'(rdy[n]), 1);
      check("rst_done",     32'(done[n]), 0);
      check("rst_s_wren",   32'(s_wren[n]), 0);
      check("rst_pt_wren",  32'(pt_wren[n]), 0);
      check("rst_key_fail", 32'(key_fail[n]), 0);
      check("rst_fail_idx", 32'(fail_idx[n]), 0);
    end

    // Identity S, DROP 0: keystream 02,05,07.
    load(0, 8'h03, 8'h43, 8'h44, 8'h45);
    run(0, 1'b0, cyc);
    check("id_latency", cyc, 19);
    check("id_pt0", pt_mem[0][0], 8'h03);
    check("id_pt1", pt_mem[0][1], 8'h41);
    check("id_pt2", pt_mem[0][2], 8'h41);
    check("id_pt3", pt_mem[0][3], 8'h42);
    check("id_key_fail", 32'(key_fail[0]), 0);
    check("id_fail_idx", 32'(fail_idx[0]), 0);
    check("id_s2", s_mem[0][2], 8'h03);
    check("id_s3", s_mem[0][3], 8'h05);
    check("id_s5", s_mem[0][5], 8'h02);
    check("id_s_writes", swr_cnt[0], 6);
    check("id_pt_writes", ptw_cnt[0], 4);

    // DROP 1: first keystream byte 02 discarded.
    load(1, 8'h02, 8'h44, 8'h45, 8'h00);
    run(1, 1'b0, cyc);
    check("drop_latency", cyc, 19);
    check("drop_pt0", pt_mem[1][0], 8'h02);
    check("drop_pt1", pt_mem[1][1], 8'h41);
    check("drop_pt2", pt_mem[1][2], 8'h42);
    check("drop_pt_writes", ptw_cnt[1], 3);
    check("drop_key_fail", 32'(key_fail[1]), 0);

    // Abort on first failing byte (02^02 = 00).
    load(0, 8'h03, 8'h02, 8'h44, 8'h45);
    run(0, 1'b0, cyc);
    check("abort_latency", cyc, 7);
    check("abort_pt0", pt_mem[0][0], 8'h03);
    check("abort_pt1", pt_mem[0][1], 8'h00);
    check("abort_pt2", pt_mem[0][2], 8'hEE);
    check("abort_pt3", pt_mem[0][3], 8'hEE);
    check("abort_key_fail", 32'(key_fail[0]), 1);
    check("abort_fail_idx", 32'(fail_idx[0]), 1);

    // Same vector, no abort: whole message decrypted.
    load(2, 8'h03, 8'h02, 8'h44, 8'h45);
    run(2, 1'b0, cyc);
    check("noabort_latency", cyc, 19);
    check("noabort_pt1", pt_mem[2][1], 8'h00);
    check("noabort_pt2", pt_mem[2][2], 8'h41);
    check("noabort_pt3", pt_mem[2][3], 8'h42);
    check("noabort_key_fail", 32'(key_fail[2]), 1);
    check("noabort_fail_idx", 32'(fail_idx[2]), 1);

    // Zero length with en held high; also clears the earlier key_fail.
    load(0, 8'h00, 8'h55, 8'h55, 8'h55);
    run(0, 1'b1, cyc);
    check("len0_latency", cyc, 1);
    check("len0_pt0", pt_mem[0][0], 8'h00);
    check("len0_pt1", pt_mem[0][1], 8'hEE);
    check("len0_s_writes", swr_cnt[0], 0);
    check("len0_key_fail", 32'(key_fail[0]), 0);
    check("len0_fail_idx", 32'(fail_idx[0]), 0);

    // Reset during WJ of byte 2 (cycle 9 after accept).
    load(0, 8'h03, 8'h43, 8'h44, 8'h45);
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("wj2_s_wren",  32'(s_wren[0]), 1);
    check("wj2_s_addr",  s_addr[0], 8'h03);
    check("wj2_s_wdata", s_wrdata[0], 8'h02);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdy",     32'(rdy[0]), 1);
    check("midrst_s_wren",  32'(s_wren[0]), 0);
    check("midrst_pt_wren", 32'(pt_wren[0]), 0);
    check("midrst_done",    32'(done[0]), 0);

    load(0, 8'h03, 8'h43, 8'h44, 8'h45);
    run(0, 1'b0, cyc);
    check("rerun_latency", cyc, 19);
    check("rerun_pt1", pt_mem[0][1], 8'h41);
    check("rerun_pt2", pt_mem[0][2], 8'h41);
    check("rerun_pt3", pt_mem[0][3], 8'h42);
    check("rerun_key_fail", 32'(key_fail[0]), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
